// File: rtl/cmp_result_debouncer.sv
// Debounces the one-hot result flags of a 4-bit magnitude comparator.
// A relation is published only after STABLE_CNT consecutive identical valid
// samples. Each change of the published relation raises a one-cycle pulse
// and bumps a wrapping event counter. Malformed flag patterns raise a
// sticky error.
module cmp_result_debouncer #(
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned EVT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             A_GT_B,
  input  logic             A_LT_B,
  input  logic             A_EQ_B,
  input  logic             clr_err,
  output logic [1:0]       state_out,
  output logic             state_valid,
  output logic             change_pulse,
  output logic [EVT_W-1:0] evt_count,
  output logic             flag_err
);

  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CNT);

  typedef enum logic [1:0] {
    ST_EQ  = 2'b00,
    ST_LT  = 2'b01,
    ST_GT  = 2'b10,
    ST_UNK = 2'b11
  } rel_e;

  rel_e             state_q, state_d;
  rel_e             cand_q, cand_d;
  rel_e             dec;
  logic             well_formed;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             pulse_q, pulse_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic             err_q, err_d;

  // Decode the flag triple; anything that is not exactly one-hot is malformed.
  always_comb begin
    dec         = ST_UNK;
    well_formed = 1'b0;
    case ({A_GT_B, A_LT_B, A_EQ_B})
      3'b100: begin dec = ST_GT; well_formed = 1'b1; end
      3'b010: begin dec = ST_LT; well_formed = 1'b1; end
      3'b001: begin dec = ST_EQ; well_formed = 1'b1; end
      default: begin dec = ST_UNK; well_formed = 1'b0; end
    endcase
  end

  // State register for the published relation plus run tracking and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_UNK;
      cand_q  <= ST_UNK;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
      evt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
      evt_q   <= evt_d;
      err_q   <= err_d;
    end
  end

  // Next-state: extend or restart the candidate run, confirm on reaching
  // STABLE; a malformed sample aborts the run and sets the sticky error,
  // which takes priority over a same-cycle clear.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    pulse_d = 1'b0;
    evt_d   = evt_q;
    err_d   = err_q;

    if (clr_err) begin
      err_d = 1'b0;
    end

    if (in_valid) begin
      if (well_formed) begin
        if (dec == cand_q) begin
          cnt_d = (cnt_q >= STABLE) ? STABLE : cnt_q + CNT_W'(1);
        end else begin
          cand_d = dec;
          cnt_d  = CNT_W'(1);
        end
        if ((cnt_d == STABLE) && (dec != state_q)) begin
          state_d = dec;
          valid_d = 1'b1;
          pulse_d = 1'b1;
          evt_d   = evt_q + EVT_W'(1);
        end
      end else begin
        err_d  = 1'b1;
        cnt_d  = '0;
        cand_d = ST_UNK;
      end
    end
  end

  assign state_out    = state_q;
  assign state_valid  = valid_q;
  assign change_pulse = pulse_q;
  assign evt_count    = evt_q;
  assign flag_err     = err_q;

endmodule
